// File: rtl/sr_latch_sequencer.sv
// Purpose: shares the S/R drive of one SR latch between two requesters, with round-robin grants and Q feedback checking.
// Latency: grant, and S or R high, at the first edge the request is seen in IDLE; one operation takes PULSE_W+GAP_W cycles.
// Backpressure: requests are level-held until granted and ignored while busy; at most one operation per PULSE_W+GAP_W+1 cycles.
//
// Ports:
//   clk      rising-edge system clock
//   rst_n    asynchronous active-low reset
//   req_set  per-requester set request (level, held until granted)
//   req_clr  per-requester clear request (level, held until granted)
//   q_fb     latch Q feedback, checked at the end of each guard gap
//   gnt      one-hot grant, one-cycle pulse at the start of an operation
//   S, R     registered latch drives; never high together
//   busy     high while an operation is in progress
//   state_q  last commanded latch value
//   err      sticky: feedback mismatch or a requester asking set and clear at once
module sr_latch_sequencer #(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_set,
    input  logic [1:0] req_clr,
    input  logic       q_fb,
    output logic [1:0] gnt,
    output logic       S,
    output logic       R,
    output logic       busy,
    output logic       state_q,
    output logic       err
);

    // The counter only ever reaches max(PULSE_W, GAP_W)-1, so it can never wrap.
    localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
    localparam int CW    = $clog2(MAX_W) + 1;

    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_W - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        st, st_d;
    logic [CW-1:0] cnt, cnt_d;
    logic          cmd, cmd_d;   // commanded value of the operation in flight (1 = set)
    logic          ptr, ptr_d;   // requester favoured when both are eligible

    logic [1:0]    gnt_d;
    logic          s_d, r_d, busy_d, state_q_d, err_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    // A requester is eligible only with exactly one of its two bits set;
    // both bits set is a conflict and that requester is simply skipped.
    logic [1:0] elig;
    logic [1:0] confl;
    logic       win_vld;
    logic       win_idx;
    logic       win_cmd;

    assign elig    = req_set ^ req_clr;
    assign confl   = req_set & req_clr;
    assign win_vld = |elig;

    always_comb begin
        win_idx = 1'b0;
        if (elig == 2'b11) begin
            win_idx = ptr;
        end else begin
            win_idx = elig[1];
        end
        win_cmd = req_set[win_idx];
    end

    logic pulse_done;
    logic gap_done;

    assign pulse_done = (st == PULSE) && (cnt == PULSE_LAST);
    assign gap_done   = (st == GAP)   && (cnt == GAP_LAST);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // Async reset drops S/R at once, abandoning any half-driven pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st      <= IDLE;
            cnt     <= '0;
            cmd     <= 1'b0;
            ptr     <= 1'b0;
            gnt     <= 2'b00;
            S       <= 1'b0;
            R       <= 1'b0;
            busy    <= 1'b0;
            state_q <= 1'b0;
            err     <= 1'b0;
        end else begin
            st      <= st_d;
            cnt     <= cnt_d;
            cmd     <= cmd_d;
            ptr     <= ptr_d;
            gnt     <= gnt_d;
            S       <= s_d;
            R       <= r_d;
            busy    <= busy_d;
            state_q <= state_q_d;
            err     <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        st_d  = st;
        cnt_d = cnt;
        case (st)
            IDLE: begin
                if (win_vld) begin
                    st_d  = PULSE;
                    cnt_d = '0;
                end
            end
            PULSE: begin
                if (pulse_done) begin
                    st_d  = GAP;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            GAP: begin
                if (gap_done) begin
                    st_d  = IDLE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
            default: begin
                st_d  = IDLE;
                cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic (next values of the registered outputs)
    // ------------------------------------------------------------------
    always_comb begin
        gnt_d     = 2'b00;
        s_d       = S;
        r_d       = R;
        busy_d    = busy;
        state_q_d = state_q;
        err_d     = err;
        cmd_d     = cmd;
        ptr_d     = ptr;
        case (st)
            IDLE: begin
                s_d = 1'b0;
                r_d = 1'b0;
                // Conflicts are only noticed while requests are being sampled.
                if (|confl) begin
                    err_d = 1'b1;
                end
                if (win_vld) begin
                    gnt_d  = win_idx ? 2'b10 : 2'b01;
                    cmd_d  = win_cmd;
                    s_d    = win_cmd;
                    r_d    = ~win_cmd;
                    busy_d = 1'b1;
                    ptr_d  = ~win_idx;
                end
            end
            PULSE: begin
                if (pulse_done) begin
                    s_d = 1'b0;
                    r_d = 1'b0;
                end
            end
            GAP: begin
                s_d = 1'b0;
                r_d = 1'b0;
                if (gap_done) begin
                    if (q_fb != cmd) begin
                        err_d = 1'b1;
                    end
                    state_q_d = cmd;
                    busy_d    = 1'b0;
                end
            end
            default: begin
                s_d    = 1'b0;
                r_d    = 1'b0;
                busy_d = 1'b0;
            end
        endcase
    end

`ifndef SYNTHESIS
    a_no_sr_overlap: assert property (@(posedge clk) disable iff (!rst_n) !(S && R));
    a_gnt_onehot0:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
`endif

endmodule

// File: tb/tb_sr_latch_sequencer.sv
// Purpose: directed self-checking bench for sr_latch_sequencer with a behavioural SR latch on q_fb.
// Latency: drives and samples on the falling edge; expected values are hand-computed per cycle.
// Backpressure: requests are held or dropped explicitly by each directed sequence.
module tb_sr_latch_sequencer;

    logic       clk;
    logic       rst_n;
    logic [1:0] req_set;
    logic [1:0] req_clr;
    logic       q_fb;
    logic [1:0] gnt;
    logic       S;
    logic       R;
    logic       busy;
    logic       state_q;
    logic       err;

    logic latch_q    = 1'b0;
    logic fb_force0  = 1'b0;
    int   overlap    = 0;
    int   n_chk      = 0;
    int   n_pass     = 0;

    sr_latch_sequencer #(.PULSE_W(2), .GAP_W(2)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_set (req_set),
        .req_clr (req_clr),
        .q_fb    (q_fb),
        .gnt     (gnt),
        .S       (S),
        .R       (R),
        .busy    (busy),
        .state_q (state_q),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Latch model: not affected by the controller reset.
    always @(posedge clk) begin
        if (S) latch_q <= 1'b1;
        else if (R) latch_q <= 1'b0;
    end
    assign q_fb = fb_force0 ? 1'b0 : latch_q;

    always @(negedge clk) begin
        if (S && R) overlap <= overlap + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n   = 1'b0;
        req_set = 2'b00;
        req_clr = 2'b00;

        // ---------------- reset values ----------------
        repeat (3) @(negedge clk);
        chk("rst_S", S, 0);
        chk("rst_R", R, 0);
        chk("rst_gnt", gnt, 0);
        chk("rst_busy", busy, 0);
        chk("rst_state_q", state_q, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- single set, held ----------------
        req_set = 2'b01;
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_gnt", gnt, (k == 0 || k == 5) ? 2'b01 : 2'b00);
            chk("t1_S", S, (k == 0 || k == 1 || k == 5) ? 1 : 0);
            chk("t1_R", R, 0);
            chk("t1_busy", busy, (k == 4) ? 0 : 1);
            if (k == 4) begin
                chk("t1_state_q", state_q, 1);
                chk("t1_err", err, 0);
            end
        end
        req_set = 2'b00;
        repeat (4) @(negedge clk);
        chk("t1_idle", busy, 0);

        // ---------------- contention ----------------
        do_reset();
        req_set = 2'b01;
        req_clr = 2'b10;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            chk("t2_gnt", gnt, (k == 0 || k == 10) ? 2'b01 : (k == 5) ? 2'b10 : 2'b00);
            chk("t2_S", S, (k == 0 || k == 1 || k == 10 || k == 11) ? 1 : 0);
            chk("t2_R", R, (k == 5 || k == 6) ? 1 : 0);
            chk("t2_busy", busy, (k % 5 == 4) ? 0 : 1);
        end
        req_set = 2'b00;
        req_clr = 2'b00;
        chk("t2_state_q", state_q, 1);
        chk("t2_err", err, 0);

        // ---------------- conflict ----------------
        do_reset();
        req_set = 2'b01;
        req_clr = 2'b11;
        @(negedge clk);
        chk("t3_err", err, 1);
        chk("t3_gnt", gnt, 2'b10);
        chk("t3_R", R, 1);
        chk("t3_S", S, 0);
        req_set = 2'b00;
        req_clr = 2'b00;
        @(negedge clk);
        chk("t3_R_hold", R, 1);
        repeat (3) @(negedge clk);
        chk("t3_busy", busy, 0);
        chk("t3_state_q", state_q, 0);
        chk("t3_err_sticky", err, 1);

        // ---------------- feedback fault ----------------
        do_reset();
        chk("t4_err_cleared", err, 0);
        fb_force0 = 1'b1;
        req_set   = 2'b01;
        @(negedge clk);
        chk("t4_gnt", gnt, 2'b01);
        chk("t4_S", S, 1);
        req_set = 2'b00;
        repeat (3) @(negedge clk);
        chk("t4_err_before", err, 0);
        chk("t4_busy_before", busy, 1);
        @(negedge clk);
        chk("t4_err", err, 1);
        chk("t4_state_q", state_q, 1);
        chk("t4_busy", busy, 0);
        fb_force0 = 1'b0;
        repeat (5) @(negedge clk);
        chk("t4_err_sticky", err, 1);
        do_reset();
        chk("t4_err_reset", err, 0);
        chk("t4_state_q_reset", state_q, 0);

        // ---------------- mid-pulse reset ----------------
        req_clr = 2'b01;
        @(negedge clk);
        chk("t5_gnt", gnt, 2'b01);
        chk("t5_R", R, 1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_R", R, 0);
        chk("t5_async_S", S, 0);
        chk("t5_async_busy", busy, 0);
        chk("t5_async_gnt", gnt, 0);
        chk("t5_async_state_q", state_q, 0);
        chk("t5_async_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_regrant_gnt", gnt, 2'b01);
        chk("t5_regrant_R", R, 1);
        req_clr = 2'b00;
        repeat (4) @(negedge clk);
        chk("t5_busy", busy, 0);
        chk("t5_state_q", state_q, 0);
        chk("t5_err", err, 0);

        chk("sr_overlap", overlap, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sr_latch_sequencer.md
# sr_latch_sequencer

Synchronous controller that owns the S/R inputs of one SR latch and shares them between two requesters. It arbitrates set/clear requests round-robin and drives fixed-width, never-overlapping S and R pulses, so the forbidden S=R=1 input can never occur. After each pulse and a guard gap it checks the latch's Q feedback against the commanded value. It sits between requester logic (e.g. debounced buttons, counters) and the latch primitive.

## Interface
- PULSE_W, 2, cycles S or R is held high per operation (>=1)
- GAP_W, 2, dead cycles with S=R=0 after each pulse before feedback check (>=1)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_set  in  2  per-requester set request, level, held until granted
- req_clr  in  2  per-requester clear request, level, held until granted
- q_fb  in  1  latch Q feedback
- gnt  out  2  one-hot grant, one-cycle pulse
- S  out  1  latch set drive (registered)
- R  out  1  latch reset drive (registered)
- busy  out  1  high while an operation is in progress
- state_q  out  1  last commanded latch value
- err  out  1  sticky error: feedback mismatch or conflicting request

## Operation
- One clock domain. Reset is asynchronous and active-low (rst_n). All outputs are registered.
- Reset values: S=0, R=0, gnt=00, busy=0, state_q=0, err=0, FSM=IDLE, round-robin pointer favours requester 0.
- Requester i is eligible when exactly one of req_set[i] or req_clr[i] is high.
- Requester i with both bits high is a conflict: err is set at that edge and requester i is skipped. The other requester may still be granted in the same cycle.
- Round-robin arbitration: when both requesters are eligible, the one not granted last wins. The pointer updates only on a grant.
- FSM states:
  - IDLE: at an edge with an eligible requester, go to PULSE. Register gnt=onehot(winner), busy=1, counter=0, and S=1 for set or R=1 for clear.
  - PULSE: hold S or R for PULSE_W cycles. Then clear S and R and go to GAP.
  - GAP: S=R=0 for GAP_W cycles. On the final edge, sample q_fb. If q_fb differs from the commanded value, set err. Then load state_q with the commanded value, set busy=0 and go to IDLE.
- Requests are sampled only in IDLE. Changes during PULSE or GAP are ignored.
- A redundant request (command equals state_q) still executes a full pulse.
- S and R are never high in the same cycle, under any input.
- err is cleared only by reset.
- Reset asserted mid-operation: S and R drop to 0 immediately (asynchronously) and all state returns to reset values. A partially driven pulse is abandoned and no err is raised.

## Timing
- Let E0 be the IDLE edge where a grant occurs.
- gnt is high for exactly cycle E0..E0+1.
- S or R is high from E0 to E0+PULSE_W.
- S=R=0 from E0+PULSE_W to E0+PULSE_W+GAP_W.
- At edge E0+PULSE_W+GAP_W: q_fb is sampled, state_q and err update, busy falls and the FSM returns to IDLE.
- Earliest next grant: edge E0+PULSE_W+GAP_W+1. Back-to-back operations start every PULSE_W+GAP_W+1 cycles.
- Grant latency from a request first seen in IDLE: 0 cycles (same edge).
- Counter width is clog2(max(PULSE_W, GAP_W))+1. The counter cannot wrap for any legal parameter value.

## Test plan
Bench uses PULSE_W=2, GAP_W=2, with an SR latch model driving q_fb.
- Reset then single set: req_set=01 held -> gnt=01 for 1 cycle; S high 2 cycles; R never high; after 4 cycles busy=0, state_q=1, err=0; next grant no earlier than 5 cycles after the first.
- Contention: req_set[0]=1 and req_clr[1]=1 held continuously -> grants alternate 01,10,01 at 5-cycle spacing; S and R pulses alternate; no cycle with S=R=1.
- Conflict: req_set=01, req_clr=01 -> err=1, no gnt to requester 0; req_clr[1] raised in the same cycle -> gnt=10 and an R pulse occurs.
- Feedback fault: q_fb forced to 0 during a set operation -> err=1 at edge E0+4; state_q=1; err stays high until rst_n is asserted low.
- Mid-pulse reset: rst_n low one cycle after E0 -> S=0 immediately (before the next clock edge); busy=0, gnt=00, state_q=0, err=0; after reset is released, a pending request is granted normally.
